// File: rtl/pipe_credit_buffer_if.sv
// Handshake bundle between the pipeliner producer/consumer side and the
// credit buffer: credit issue, pipeliner output, consumer ready/valid, status.
interface pipe_credit_buffer_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic             issue;
  logic             can_issue;
  logic [CW-1:0]    credits;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [CW-1:0]    occupancy;
  logic             err_overflow;
  logic             err_credit;

  modport master (
    output issue, in_valid, in_data, out_ready,
    input  can_issue, credits, out_valid, out_data, occupancy, err_overflow, err_credit
  );

  modport slave (
    input  issue, in_valid, in_data, out_ready,
    output can_issue, credits, out_valid, out_data, occupancy, err_overflow, err_credit
  );
endinterface

// File: rtl/pipe_credit_buffer.sv
// Elastic receive buffer behind a non-stallable pipeliner; hands credits to
// the producer so in-flight plus stored items never exceed DEPTH.
module pipe_credit_buffer #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input logic                clk,
  input logic                reset,
  pipe_credit_buffer_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    occ_r;
  logic [CW-1:0]    credits_r;
  logic             err_overflow_r;
  logic             err_credit_r;

  logic             push_s;
  logic             pop_s;
  logic             take_s;
  logic [CW-1:0]    occ_nxt_s;
  logic [CW-1:0]    credits_nxt_s;

  // Handshake qualifiers; a pop frees a slot for a push in the same cycle.
  always_comb begin
    pop_s  = (occ_r != {CW{1'b0}}) && bus.out_ready;
    push_s = bus.in_valid && ((occ_r < CW'(DEPTH)) || pop_s);
    take_s = bus.issue && (credits_r != {CW{1'b0}});
  end

  // Occupancy next-state.
  always_comb begin
    occ_nxt_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_nxt_s = occ_r + CW'(1);
      2'b01:   occ_nxt_s = occ_r - CW'(1);
      default: occ_nxt_s = occ_r;
    endcase
  end

  // Credit next-state; returning a credit saturates at DEPTH.
  always_comb begin
    credits_nxt_s = credits_r;
    case ({take_s, pop_s})
      2'b10: credits_nxt_s = credits_r - CW'(1);
      2'b01: begin
        if (credits_r != CW'(DEPTH)) begin
          credits_nxt_s = credits_r + CW'(1);
        end else begin
          credits_nxt_s = credits_r;
        end
      end
      default: credits_nxt_s = credits_r;
    endcase
  end

  // Storage write port; contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= bus.in_data;
    end
  end

  // Pointers, counters and sticky error flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r       <= {AW{1'b0}};
      rd_ptr_r       <= {AW{1'b0}};
      occ_r          <= {CW{1'b0}};
      credits_r      <= CW'(DEPTH);
      err_overflow_r <= 1'b0;
      err_credit_r   <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      occ_r     <= occ_nxt_s;
      credits_r <= credits_nxt_s;
      if (bus.in_valid && !push_s) begin
        err_overflow_r <= 1'b1;
      end
      if (bus.issue && !take_s) begin
        err_credit_r <= 1'b1;
      end
    end
  end

  // Outputs are decoded straight from registered state only.
  always_comb begin
    bus.out_valid    = (occ_r != {CW{1'b0}});
    bus.out_data     = mem_r[rd_ptr_r];
    bus.can_issue    = (credits_r != {CW{1'b0}});
    bus.credits      = credits_r;
    bus.occupancy    = occ_r;
    bus.err_overflow = err_overflow_r;
    bus.err_credit   = err_credit_r;
  end
endmodule
